// File: rtl/mem_port_arbiter.sv
// Fixed-priority (MEM over IF) arbiter sharing one synchronous memory bus between
// the fetch and data ports, with registered bus outputs, fetch flush and bus-hang timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_valid_o,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,

    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic              bus_err_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIfWait,
        StMemWait,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              discard_q;
    logic [DATA_W-1:0] cap_data;
    logic              fetch_dropped;

    // A timed-out transaction completes with zero data.
    assign cap_data      = bus_ack_i ? bus_rdata_i : '0;
    assign fetch_dropped = discard_q | if_flush_i;

    // Gated by reset so the pipeline sees no stall while the arbiter is held in reset.
    assign stallreq_mem_o = rst & mem_req_i & ~mem_valid_o;
    assign stallreq_if_o  = rst & if_req_i & ~if_valid_o & ~if_flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            if_rdata_o  <= '0;
            if_valid_o  <= 1'b0;
            mem_rdata_o <= '0;
            mem_valid_o <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
        end else begin
            if_valid_o  <= 1'b0;
            mem_valid_o <= 1'b0;
            bus_err_o   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_req_i) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        state_q     <= StMemWait;
                    end else if (if_req_i && !if_flush_i) begin
                        bus_req_o  <= 1'b1;
                        bus_we_o   <= 1'b0;
                        bus_sel_o  <= 4'hF;
                        bus_addr_o <= if_addr_i;
                        state_q    <= StIfWait;
                    end
                end
                StIfWait, StMemWait: begin
                    if (state_q == StIfWait && if_flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (bus_ack_i || cnt_q == CntLast) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= ~bus_ack_i;
                        state_q   <= StDone;
                        if (state_q == StMemWait) begin
                            mem_valid_o <= 1'b1;
                            if (!bus_we_o) begin
                                mem_rdata_o <= cap_data;
                            end
                        end else if (!fetch_dropped) begin
                            if_valid_o <= 1'b1;
                            if_rdata_o <= cap_data;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    cnt_q     <= '0;
                    discard_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations at hand-computed cycles.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_flush_i = 1'b0;
    logic [DW-1:0] if_rdata_o;
    logic          if_valid_o;
    logic          mem_req_i = 1'b0;
    logic          mem_we_i = 1'b0;
    logic [3:0]    mem_sel_i = '0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_wdata_i = '0;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_valid_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [3:0]    bus_sel_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic          bus_ack_i = 1'b0;
    logic [DW-1:0] bus_rdata_i = '0;
    logic          stallreq_if_o;
    logic          stallreq_mem_o;
    logic          bus_err_o;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_flush_i    (if_flush_i),
        .if_rdata_o    (if_rdata_o),
        .if_valid_o    (if_valid_o),
        .mem_req_i     (mem_req_i),
        .mem_we_i      (mem_we_i),
        .mem_sel_i     (mem_sel_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_valid_o   (mem_valid_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_sel_o     (bus_sel_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i   (bus_rdata_i),
        .stallreq_if_o (stallreq_if_o),
        .stallreq_mem_o(stallreq_mem_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus slave: acks after ack_waits extra request cycles, or never when no_ack is set.
    int          ack_waits = 0;
    logic [31:0] resp_data = '0;
    bit          no_ack = 1'b0;
    int          wcnt = 0;

    always @(posedge clk) begin
        #1;
        if (bus_req_o) begin
            if (!no_ack && wcnt == ack_waits) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = resp_data;
                wcnt        = 0;
            end else begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = 32'hFFFF_FFFF;
                wcnt++;
            end
        end else begin
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'hFFFF_FFFF;
            wcnt        = 0;
        end
    end

    // Transaction-level model: one open transaction at most, one cool-down cycle after it.
    bit          m_open = 0, m_mem = 0, m_we = 0, m_disc = 0, m_cool = 0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    int          m_age = 0;
    bit          e_ifv = 0, e_memv = 0, e_err = 0;
    logic [31:0] e_if_rd = '0, e_mem_rd = '0;

    always @(negedge clk) begin
        logic [31:0] data;
        if (!rst) begin
            m_open = 0; m_cool = 0; m_disc = 0; m_age = 0;
            e_ifv = 0; e_memv = 0; e_err = 0; e_if_rd = '0; e_mem_rd = '0;
        end
        check("bus_req", bus_req_o, m_open);
        if (m_open) begin
            check("bus_we", bus_we_o, m_we);
            check("bus_sel", bus_sel_o, m_sel);
            check("bus_addr", bus_addr_o, m_addr);
            if (m_we) check("bus_wdata", bus_wdata_o, m_wdata);
        end else if (!rst) begin
            check("bus_addr_reset", bus_addr_o, 0);
            check("bus_sel_reset", bus_sel_o, 0);
        end
        check("if_valid", if_valid_o, e_ifv);
        check("mem_valid", mem_valid_o, e_memv);
        check("bus_err", bus_err_o, e_err);
        check("if_rdata", if_rdata_o, e_if_rd);
        check("mem_rdata", mem_rdata_o, e_mem_rd);
        check("stall_mem", stallreq_mem_o, rst & mem_req_i & ~e_memv);
        check("stall_if", stallreq_if_o, rst & if_req_i & ~e_ifv & ~if_flush_i);

        if (rst) begin
            e_ifv = 0; e_memv = 0; e_err = 0;
            if (m_open) begin
                m_age++;
                if (!m_mem && if_flush_i) m_disc = 1;
                if (bus_ack_i || m_age == TO) begin
                    data = bus_ack_i ? bus_rdata_i : 32'h0;
                    e_err = !bus_ack_i;
                    if (m_mem) begin
                        e_memv = 1;
                        if (!m_we) e_mem_rd = data;
                    end else if (!m_disc) begin
                        e_ifv = 1;
                        e_if_rd = data;
                    end
                    m_open = 0;
                    m_cool = 1;
                end
            end else if (m_cool) begin
                m_cool = 0;
                m_disc = 0;
            end else if (mem_req_i) begin
                m_open = 1; m_mem = 1; m_we = mem_we_i; m_sel = mem_sel_i;
                m_addr = mem_addr_i; m_wdata = mem_wdata_i; m_age = 0; m_disc = 0;
            end else if (if_req_i && !if_flush_i) begin
                m_open = 1; m_mem = 0; m_we = 0; m_sel = 4'hF;
                m_addr = if_addr_i; m_wdata = '0; m_age = 0; m_disc = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mid();
        check("rst_bus_req", bus_req_o, 0);
        check("rst_if_rdata", if_rdata_o, 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Zero-wait fetch
        ack_waits = 0; resp_data = 32'h3421_0005; no_ack = 0;
        if_req_i = 1; if_addr_i = 32'h0000_0100;
        mid();
        check("t1_stall_c0", stallreq_if_o, 1);
        check("t1_busreq_c0", bus_req_o, 0);
        next_cycle(); mid();
        check("t1_busreq_c1", bus_req_o, 1);
        check("t1_addr_c1", bus_addr_o, 32'h100);
        check("t1_sel_c1", bus_sel_o, 4'hF);
        check("t1_stall_c1", stallreq_if_o, 1);
        next_cycle(); mid();
        check("t1_valid_c2", if_valid_o, 1);
        check("t1_rdata_c2", if_rdata_o, 32'h3421_0005);
        check("t1_stall_c2", stallreq_if_o, 0);
        next_cycle();
        if_req_i = 0;
        mid();
        check("t1_valid_c3", if_valid_o, 0);
        next_cycle();

        // Conflict: MEM read wins, IF follows
        ack_waits = 2; resp_data = 32'hAAAA_5555;
        if_req_i = 1; if_addr_i = 32'h104;
        mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h200;
        mid();
        check("t2_stall_mem_c0", stallreq_mem_o, 1);
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); mid();
            check("t2_addr_mem", bus_addr_o, 32'h200);
            check("t2_stall_if", stallreq_if_o, 1);
        end
        next_cycle(); mid();
        check("t2_mem_valid_c4", mem_valid_o, 1);
        check("t2_mem_rdata_c4", mem_rdata_o, 32'hAAAA_5555);
        check("t2_stall_if_c4", stallreq_if_o, 1);
        next_cycle();
        mem_req_i = 0; resp_data = 32'h0BAD_F00D;
        mid();
        check("t2_busreq_c5", bus_req_o, 0);
        next_cycle(); mid();
        check("t2_busreq_c6", bus_req_o, 1);
        check("t2_addr_c6", bus_addr_o, 32'h104);
        repeat (3) next_cycle();
        mid();
        check("t2_if_valid_c9", if_valid_o, 1);
        check("t2_if_rdata_c9", if_rdata_o, 32'h0BAD_F00D);
        next_cycle();
        if_req_i = 0;
        next_cycle();

        // MEM write, inputs change while the bus must hold
        ack_waits = 3; resp_data = 32'h1111_1111;
        mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h300; mem_wdata_i = 32'hDEAD_BEEF;
        next_cycle();
        mem_addr_i = 32'h3FC; mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            mid();
            check("t3_busreq", bus_req_o, 1);
            check("t3_addr", bus_addr_o, 32'h300);
            check("t3_wdata", bus_wdata_o, 32'hDEAD_BEEF);
            check("t3_sel", bus_sel_o, 4'b0011);
            check("t3_we", bus_we_o, 1);
            next_cycle();
        end
        mid();
        check("t3_mem_valid", mem_valid_o, 1);
        check("t3_mem_rdata_kept", mem_rdata_o, 32'hAAAA_5555);
        next_cycle();
        mem_req_i = 0; mem_we_i = 0;
        next_cycle();

        // Flush during IF_WAIT
        ack_waits = 3; resp_data = 32'h1234_5678;
        if_req_i = 1; if_addr_i = 32'h400;
        next_cycle();
        if_flush_i = 1;
        mid();
        check("t4_busreq_c1", bus_req_o, 1);
        check("t4_stall_flush", stallreq_if_o, 0);
        next_cycle();
        if_flush_i = 0;
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) if_req_i = 0;
            mid();
            check("t4_no_valid", if_valid_o, 0);
            check("t4_rdata_kept", if_rdata_o, 32'h0BAD_F00D);
            next_cycle();
        end
        ack_waits = 0; resp_data = 32'h5566_7788;
        next_cycle();
        if_req_i = 1; if_addr_i = 32'h404;
        next_cycle(); mid();
        check("t4_addr_refetch", bus_addr_o, 32'h404);
        next_cycle(); mid();
        check("t4_valid_refetch", if_valid_o, 1);
        check("t4_rdata_refetch", if_rdata_o, 32'h5566_7788);
        next_cycle();
        if_req_i = 0;
        next_cycle();

        // Timeout on a MEM read
        no_ack = 1;
        mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h500;
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); mid();
            check("t5_busreq", bus_req_o, 1);
            check("t5_no_err", bus_err_o, 0);
        end
        next_cycle(); mid();
        check("t5_err", bus_err_o, 1);
        check("t5_mem_valid", mem_valid_o, 1);
        check("t5_mem_rdata", mem_rdata_o, 0);
        next_cycle();
        mem_req_i = 0;
        mid();
        check("t5_err_c6", bus_err_o, 0);
        check("t5_busreq_c6", bus_req_o, 0);
        next_cycle();

        // Async reset in the middle of MEM_WAIT
        mem_req_i = 1; mem_addr_i = 32'h600;
        next_cycle(); next_cycle(); mid();
        check("t6_busreq_before", bus_req_o, 1);
        #2 rst = 1'b0;
        #1;
        check("t6_busreq_async", bus_req_o, 0);
        check("t6_stall_mem_async", stallreq_mem_o, 0);
        check("t6_addr_async", bus_addr_o, 0);
        check("t6_mem_valid_async", mem_valid_o, 0);
        next_cycle();
        mem_req_i = 0; no_ack = 0; ack_waits = 0; resp_data = 32'hCAFE_F00D;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        if_req_i = 1; if_addr_i = 32'h700;
        mid();
        check("t6_if_rdata_cleared", if_rdata_o, 0);
        next_cycle(); mid();
        check("t6_addr_after", bus_addr_o, 32'h700);
        next_cycle(); mid();
        check("t6_valid_after", if_valid_o, 1);
        check("t6_rdata_after", if_rdata_o, 32'hCAFE_F00D);
        next_cycle();
        if_req_i = 0;
        repeat (2) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d, mismatched %0d", n_cmp, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external synchronous memory bus between the instruction-fetch (IF) port and the data-access (MEM) port of the 5-stage pipeline.
- Grants the bus with fixed priority, MEM over IF, because MEM holds the older instruction.
- Registers all bus outputs and holds them stable until the bus acknowledges.
- Raises per-port stall requests to the pipeline controller.
- Handles IF flush on taken branches and a bus-hang timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting for bus_ack_i before forced completion (must be ≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
if_req_i  in  1  IF read request, held until if_valid_o
if_addr_i  in  ADDR_W  fetch address
if_flush_i  in  1  discard the in-flight or pending fetch
if_rdata_o  out  DATA_W  fetched instruction
if_valid_o  out  1  one-cycle fetch completion pulse
mem_req_i  in  1  MEM request, held until mem_valid_o
mem_we_i  in  1  1 = write
mem_sel_i  in  4  byte lane enables
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  write data
mem_rdata_o  out  DATA_W  load data
mem_valid_o  out  1  one-cycle MEM completion pulse
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write enable
bus_sel_o  out  4  bus byte enables
bus_addr_o  out  ADDR_W  bus address
bus_wdata_o  out  DATA_W  bus write data
bus_ack_i  in  1  bus completion, sampled on clk
bus_rdata_i  in  DATA_W  bus read data, valid with bus_ack_i
stallreq_if_o  out  1  IF stall request
stallreq_mem_o  out  1  MEM stall request
bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst low, async):
  - State IDLE.
  - All outputs 0, including rdata registers, bus_* outputs and the timeout counter.
  - A transaction in flight is abandoned; bus_req_o drops immediately.
- States: IDLE, IF_WAIT, MEM_WAIT, DONE.
- IDLE:
  - mem_req_i=1: latch MEM address, we, sel and wdata into the bus_* registers, set bus_req_o=1, go to MEM_WAIT.
  - Else if_req_i=1 and if_flush_i=0: latch if_addr_i with bus_we_o=0 and bus_sel_o=4'hF, set bus_req_o=1, go to IF_WAIT.
  - Else stay in IDLE.
- IF_WAIT / MEM_WAIT:
  - bus_* outputs are held constant.
  - Counter increments each cycle.
  - On bus_ack_i=1: bus_req_o<=0, go to DONE, capture bus_rdata_i.
    - IF reads update if_rdata_o.
    - MEM reads update mem_rdata_o.
    - MEM writes leave mem_rdata_o unchanged.
  - Counter reaching TIMEOUT with no ack: same as ack but captured data = 0, and bus_err_o pulses in the DONE cycle.
- DONE (exactly 1 cycle):
  - The owning port's valid_o = 1, unless the fetch is marked discarded.
  - Counter cleared.
  - No new grant is issued; next state is IDLE.
- Latency: zero-wait bus gives request at cycle 0, bus_req_o at cycle 1, ack at cycle 1, valid at cycle 2. Back-to-back transactions take ≥3 cycles each.
- Stalls (combinational):
  - stallreq_mem_o = mem_req_i & ~mem_valid_o.
  - stallreq_if_o = if_req_i & ~if_valid_o & ~if_flush_i.
- Flush:
  - if_flush_i=1 in IF_WAIT sets a discard flag. The bus transaction still completes (it cannot be aborted), if_valid_o stays 0 and if_rdata_o is not updated.
  - The flag clears on DONE and on reset.
  - Flush in IDLE simply suppresses an IF grant that cycle.
- Simultaneous requests: MEM wins. IF waits and is granted in the IDLE following MEM's DONE, if still requested.
- Requests that drop before completion: the transaction still completes; valid still pulses and is ignored.
- bus_ack_i outside the WAIT states is ignored.

Test Plan:
- Zero-wait IF read: if_req_i=1, addr 0x0000_0100, ack in the first bus_req_o cycle with rdata 0x3421_0005 -> bus_addr_o=0x100 at cycle 1; if_valid_o=1 with if_rdata_o=0x34210005 at cycle 2; stallreq_if_o high cycles 0-1 only.
- Conflict: if_req_i and mem_req_i (read 0x200) both asserted at cycle 0, ack after 2 waits -> MEM served first; mem_valid_o at cycle 4; IF bus_req_o at cycle 6; stallreq_if_o high throughout.
- MEM write: mem_we_i=1, sel=4'b0011, addr 0x300, wdata 0xDEAD_BEEF, ack after 3 waits -> bus_* stable all 4 request cycles; mem_valid_o pulses; mem_rdata_o unchanged.
- Flush: if_flush_i pulsed during IF_WAIT, ack later with 0x1234_5678 -> no if_valid_o; if_rdata_o keeps its old value; next IF request served normally.
- Timeout with TIMEOUT=4, bus_ack_i never asserted -> bus_err_o and valid pulse together after 4 wait cycles; rdata=0; state returns to IDLE.
- Async reset asserted mid MEM_WAIT -> bus_req_o, stalls and valids go to 0 immediately; after release, a new IF request is granted normally.
